// File: rtl/data_register_pkg.sv
// Shared configuration for the generic datapath register.
// Holds the default datapath width used when the register is instantiated.
package data_register_pkg;

    localparam int unsigned DATA_REGISTER_WIDTH = 8;

endpackage : data_register_pkg

// File: rtl/data_register.sv
// Loadable storage register with synchronous clear.
// Building block for the accumulator, instruction register and similar state.
module data_register
    import data_register_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_REGISTER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = data_in;
        end
    end

    // NOTE: the clear is synchronous, so rst sits inside the edge-triggered block, and it takes priority over load.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    // Output comes straight from the flop; no input reaches it combinationally.
    assign data_out = data_q;

endmodule : data_register

// File: tb/tb_data_register.sv
// Directed, table-driven bench for data_register (WIDTH = 8).
// Inputs change on the falling edge; data_out is checked on the next falling edge.
module tb_data_register;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         load;
    logic [W-1:0] data_in;
    logic [W-1:0] data_out;

    int compared   = 0;
    int mismatched = 0;

    data_register #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         load;
        logic [W-1:0] din;
        logic [W-1:0] exp;
        string        name;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [W-1:0] actual,
                         input logic [W-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s at %0t: rst=%b load=%b data_in=%h got=%h want=%h",
                     name, $time, rst, load, data_in, actual, expected);
        end
    endtask

    task automatic set_vec(input int i, input logic r, input logic l,
                           input logic [W-1:0] d, input logic [W-1:0] e,
                           input string n);
        vecs[i].rst  = r;
        vecs[i].load = l;
        vecs[i].din  = d;
        vecs[i].exp  = e;
        vecs[i].name = n;
    endtask

    initial begin
        set_vec( 0, 1'b1, 1'b0, 8'h00, 8'h00, "initial_reset");
        set_vec( 1, 1'b0, 1'b1, 8'h55, 8'h55, "load_55");
        set_vec( 2, 1'b0, 1'b1, 8'hAA, 8'hAA, "load_AA_overwrite");
        set_vec( 3, 1'b0, 1'b1, 8'hFF, 8'hFF, "load_FF");
        set_vec( 4, 1'b1, 1'b1, 8'hFF, 8'h00, "reset_beats_load");
        set_vec( 5, 1'b0, 1'b1, 8'hAA, 8'hAA, "reload_AA");
        set_vec( 6, 1'b0, 1'b0, 8'h3C, 8'hAA, "hold_1");
        set_vec( 7, 1'b0, 1'b0, 8'h3C, 8'hAA, "hold_2");
        set_vec( 8, 1'b0, 1'b0, 8'h3C, 8'hAA, "hold_3");
        set_vec( 9, 1'b1, 1'b0, 8'h3C, 8'h00, "reset_pulse");
        set_vec(10, 1'b0, 1'b1, 8'h01, 8'h01, "load_after_reset");
        set_vec(11, 1'b1, 1'b1, 8'h77, 8'h00, "long_reset_1");
        set_vec(12, 1'b1, 1'b1, 8'h88, 8'h00, "long_reset_2");
        set_vec(13, 1'b1, 1'b0, 8'h99, 8'h00, "long_reset_3");
        set_vec(14, 1'b0, 1'b1, 8'h80, 8'h80, "first_edge_after_reset");
        set_vec(15, 1'b0, 1'b1, 8'h12, 8'h12, "b2b_12");
        set_vec(16, 1'b0, 1'b1, 8'h34, 8'h34, "b2b_34");
        set_vec(17, 1'b0, 1'b1, 8'h56, 8'h56, "b2b_56");
        set_vec(18, 1'b0, 1'b0, 8'hE7, 8'h56, "hold_56");
        set_vec(19, 1'b0, 1'b1, 8'h00, 8'h00, "load_zero");

        rst     = 1'b0;
        load    = 1'b0;
        data_in = '0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            if (i > 0) check(vecs[i-1].name, data_out, vecs[i-1].exp);
            rst     = vecs[i].rst;
            load    = vecs[i].load;
            data_in = vecs[i].din;
        end
        @(negedge clk);
        check(vecs[NVEC-1].name, data_out, vecs[NVEC-1].exp);

        // No combinational path: changing inputs mid-cycle must not move data_out.
        rst     = 1'b0;
        load    = 1'b1;
        data_in = 8'hC3;
        #2;
        check("no_comb_path_load", data_out, 8'h00);
        rst = 1'b1;
        #1;
        check("no_async_reset_effect", data_out, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        check("captured_C3", data_out, 8'hC3);

        // Reset asserted mid-cycle with data held: output stays until the edge.
        load    = 1'b0;
        data_in = 8'h5A;
        rst     = 1'b1;
        #2;
        check("rst_no_async_clear", data_out, 8'hC3);
        @(negedge clk);
        check("rst_clears_on_edge", data_out, 8'h00);
        rst  = 1'b0;
        load = 1'b0;
        @(negedge clk);
        check("hold_zero_after_reset", data_out, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_data_register
